// File: rtl/crc_feeder_pkg.sv
// crc_feeder_pkg: CRC-32C engine register map, control/status codes and sequencer states
package crc_feeder_pkg;
    localparam logic [15:0] ADDR_IN     = 16'h0640;
    localparam logic [15:0] ADDR_STATE  = 16'h0648;
    localparam logic [15:0] ADDR_RESULT = 16'h0650;
    localparam logic [15:0] ADDR_CTRL   = 16'h0658;
    localparam logic [31:0] CTRL_PUT  = 32'd1;
    localparam logic [31:0] CTRL_GET  = 32'd2;
    localparam logic [31:0] CTRL_CLR  = 32'd3;
    localparam logic [31:0] ENG_BUSY  = 32'd0;
    localparam logic [31:0] ENG_READ  = 32'd1;
    localparam logic [31:0] ENG_FULL  = 32'd2;
    localparam logic [31:0] ENG_READY = 32'd3;
    localparam logic [31:0] ENG_ERROR = 32'd4;
    typedef enum logic [3:0] {
        S_IDLE, S_CLR_WR, S_IN_WR, S_PUT_WR, S_GET_WR, S_GET_POLL, S_RES_RD, S_RESULT_OUT
    } state_e;
    // FETCH: no bus cycle (IN_WR uses it to pop a byte); WAIT: idle gap after CTRL writes
    typedef enum logic [2:0] {PH_FETCH, PH_SETUP, PH_STROBE, PH_HOLD, PH_WAIT} phase_e;
endpackage

// File: rtl/crc_byte_fifo.sv
// crc_byte_fifo: first-word-fall-through FIFO of message bytes tagged with a last flag
module crc_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       wr_en_i,
    input  logic [8:0] wr_data_i,
    input  logic       rd_en_i,
    output logic [8:0] rd_data_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [8:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    // pointers carry one extra wrap bit so full and empty are distinguishable
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end
    // storage needs no reset: only slots between the pointers are ever read
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o   = wr_ptr_q == rd_ptr_q;
    assign full_o    = wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]};
endmodule

// File: rtl/crc_feeder.sv
// crc_feeder: buffers a byte stream and drives the CRC-32C engine register protocol per message
module crc_feeder
    import crc_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BYTES  = 250,
    parameter int PUT_WAIT   = 2,
    parameter int POLL_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [7:0]  s_byte,
    input  logic        s_last,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] r_crc,
    output logic        r_err,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [15:0] m_saddress,
    output logic [31:0] m_sdata_out,
    input  logic [31:0] m_sdata_in,
    output logic        m_swr,
    output logic        m_srd,
    output logic        busy
);
    localparam int WW = $clog2(PUT_WAIT + 2);
    localparam int PW = $clog2(POLL_LIMIT + 1);
    state_e        state_q, state_d;
    phase_e        phase_q, phase_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [7:0]    cnt_q, cnt_d, byte_q, byte_d;
    logic          last_q, last_d, err_q, err_d;
    logic [31:0]   crc_q, crc_d;
    logic [8:0]    fifo_data;
    logic          full, empty, pop, fin, is_ctrl, is_rd, on_bus;
    logic [15:0]   addr;
    logic [31:0]   wdata;

    assign s_ready = !full || pop;
    assign is_ctrl = state_q inside {S_CLR_WR, S_PUT_WR, S_GET_WR};

    crc_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .n_reset(n_reset),
        .wr_en_i(s_valid && s_ready), .wr_data_i({s_last, s_byte}),
        .rd_en_i(pop), .rd_data_o(fifo_data),
        .full_o(full), .empty_o(empty)
    );

    // state register together with the per-message datapath registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            phase_q <= PH_FETCH;
            wait_q  <= '0;
            poll_q  <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            crc_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            wait_q  <= wait_d;
            poll_q  <= poll_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            err_q   <= err_d;
            crc_q   <= crc_d;
        end
    end

    // next state: bus phases advance generically, each state decides where a finished access goes
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        wait_d  = wait_q;
        poll_d  = poll_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        last_d  = last_q;
        err_d   = err_q;
        crc_d   = crc_q;
        pop     = 1'b0;
        fin     = 1'b0;
        case (phase_q)
            PH_SETUP:  phase_d = PH_STROBE;
            PH_STROBE: phase_d = PH_HOLD;
            PH_HOLD: begin
                fin     = !(is_ctrl && PUT_WAIT > 0);
                phase_d = PH_WAIT;
                wait_d  = '0;
            end
            PH_WAIT: begin
                fin    = 32'(wait_q) + 1 >= PUT_WAIT;
                wait_d = wait_q + 1'b1;
            end
            default: ;
        endcase
        case (state_q)
            S_IDLE: if (!empty) begin
                state_d = S_CLR_WR;
                phase_d = PH_SETUP;
                cnt_d   = '0;
                err_d   = 1'b0;
                crc_d   = '0;
            end
            S_CLR_WR: if (fin) begin
                state_d = S_IN_WR;
                phase_d = PH_FETCH;
            end
            S_IN_WR: if (phase_q == PH_FETCH) begin
                if (!empty) begin
                    pop    = 1'b1;
                    byte_d = fifo_data[7:0];
                    last_d = fifo_data[8];
                    // an over-length message is drained without touching the engine
                    if (32'(cnt_q) == MAX_BYTES) begin
                        err_d   = 1'b1;
                        state_d = fifo_data[8] ? S_RESULT_OUT : S_IN_WR;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        phase_d = PH_SETUP;
                    end
                end
            end else if (fin) begin
                state_d = S_PUT_WR;
                phase_d = PH_SETUP;
            end
            S_PUT_WR: if (fin) begin
                state_d = last_q ? S_GET_WR : S_IN_WR;
                phase_d = last_q ? PH_SETUP : PH_FETCH;
            end
            S_GET_WR: if (fin) begin
                state_d = S_GET_POLL;
                phase_d = PH_SETUP;
                poll_d  = '0;
            end
            S_GET_POLL: if (fin) begin
                poll_d = poll_q + 1'b1;
                if (m_sdata_in == ENG_READY) begin
                    state_d = S_RES_RD;
                    phase_d = PH_SETUP;
                end else if (m_sdata_in == ENG_ERROR || 32'(poll_q) + 1 >= POLL_LIMIT) begin
                    state_d = S_RESULT_OUT;
                    phase_d = PH_FETCH;
                    err_d   = 1'b1;
                end else begin
                    phase_d = PH_SETUP;
                end
            end
            S_RES_RD: if (fin) begin
                crc_d   = m_sdata_in;
                state_d = S_RESULT_OUT;
                phase_d = PH_FETCH;
            end
            S_RESULT_OUT: if (r_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // outputs: bus fields are driven only during SETUP/STROBE/HOLD of an access
    always_comb begin
        is_rd       = state_q inside {S_GET_POLL, S_RES_RD};
        on_bus      = phase_q inside {PH_SETUP, PH_STROBE, PH_HOLD};
        addr        = state_q == S_IN_WR ? ADDR_IN : state_q == S_GET_POLL ? ADDR_STATE :
                      state_q == S_RES_RD ? ADDR_RESULT : ADDR_CTRL;
        wdata       = state_q == S_IN_WR ? {24'h0, byte_q} : state_q == S_CLR_WR ? CTRL_CLR :
                      state_q == S_PUT_WR ? CTRL_PUT : state_q == S_GET_WR ? CTRL_GET : '0;
        m_saddress  = on_bus ? addr : '0;
        m_sdata_out = on_bus && !is_rd ? wdata : '0;
        m_swr       = phase_q == PH_STROBE && !is_rd;
        m_srd       = phase_q == PH_STROBE && is_rd;
        r_valid     = state_q == S_RESULT_OUT;
        r_err       = err_q;
        r_crc       = err_q ? '0 : crc_q;
        busy        = state_q != S_IDLE;
    end
endmodule

// File: tb/tb_crc_feeder.sv
// tb_crc_feeder: engine bus model plus result scoreboard around crc_feeder
module tb_crc_feeder;
    import crc_feeder_pkg::*;
    logic        clk = 1'b0, n_reset = 1'b0;
    logic [7:0]  s_byte = '0;
    logic        s_last = 1'b0, s_valid = 1'b0, s_ready;
    logic [31:0] r_crc;
    logic        r_err, r_valid, r_ready = 1'b1;
    logic [15:0] m_saddress;
    logic [31:0] m_sdata_out, m_sdata_in = '0;
    logic        m_swr, m_srd, busy;
    int checks = 0, failures = 0;
    typedef struct {logic [31:0] crc; logic err;} res_t;
    typedef struct {logic wr; logic [15:0] a; logic [31:0] d;} acc_t;
    typedef logic [7:0] msg_t[$];
    res_t sb[$];
    acc_t log_q[$];
    res_t exp_r;
    logic [31:0] eng_crc = '0;
    logic [7:0]  eng_in = '0;
    int eng_polls = 0, put_cnt = 0;
    bit stuck = 0;
    logic prev_strobe = 1'b0;

    crc_feeder dut (
        .clk(clk), .n_reset(n_reset),
        .s_byte(s_byte), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .r_crc(r_crc), .r_err(r_err), .r_valid(r_valid), .r_ready(r_ready),
        .m_saddress(m_saddress), .m_sdata_out(m_sdata_out), .m_sdata_in(m_sdata_in),
        .m_swr(m_swr), .m_srd(m_srd), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'h82F63B78 : r >> 1;
        return r;
    endfunction

    function automatic logic [31:0] crc_msg(input msg_t m);
        logic [31:0] c = '1;
        foreach (m[i]) c = crc_step(c, m[i]);
        return ~c;
    endfunction

    function automatic logic [48:0] pk(input acc_t x);
        return {x.wr, x.a, x.d};
    endfunction

    // engine model: samples strobes mid-cycle, answers reads before the HOLD capture edge
    always @(negedge clk) begin
        if (n_reset && (m_swr || m_srd)) begin
            chk("strobe_width", prev_strobe, 0);
            chk("wr_rd_excl", m_swr & m_srd, 0);
        end
        prev_strobe = n_reset && (m_swr || m_srd);
        if (m_swr) begin
            log_q.push_back('{1'b1, m_saddress, m_sdata_out});
            if (m_saddress == ADDR_IN) eng_in = m_sdata_out[7:0];
            else if (m_saddress == ADDR_CTRL) begin
                if (m_sdata_out == CTRL_CLR) begin
                    eng_crc = '1;
                    put_cnt = 0;
                end else if (m_sdata_out == CTRL_PUT) begin
                    eng_crc = crc_step(eng_crc, eng_in);
                    put_cnt++;
                end else if (m_sdata_out == CTRL_GET) eng_polls = 0;
            end
        end
        if (m_srd) begin
            log_q.push_back('{1'b0, m_saddress, 32'h0});
            if (m_saddress == ADDR_STATE) begin
                m_sdata_in = stuck ? ENG_BUSY : eng_polls == 0 ? ENG_BUSY : eng_polls == 1 ? ENG_READ : ENG_READY;
                eng_polls++;
            end else if (m_saddress == ADDR_RESULT) m_sdata_in = ~eng_crc;
        end
    end

    // result monitor: every accepted result is matched against the scoreboard head
    always @(negedge clk) begin
        if (n_reset && r_valid && r_ready) begin
            if (sb.size() == 0) chk("unexpected_result", r_valid, 0);
            else begin
                exp_r = sb.pop_front();
                chk("r_err", r_err, exp_r.err);
                chk("r_crc", r_crc, exp_r.crc);
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input logic l);
        int n = 0;
        s_byte = b;
        s_last = l;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("push_ready", s_ready, 1);
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic send(input msg_t m, input logic [31:0] crc, input logic err);
        sb.push_back('{crc, err});
        foreach (m[i]) push_byte(m[i], i == m.size() - 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sb.size() + 32'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_s_ready"}, s_ready, 1);
        chk({p, "_r_valid"}, r_valid, 0);
        chk({p, "_r_err"}, r_err, 0);
        chk({p, "_r_crc"}, r_crc, 0);
        chk({p, "_addr"}, m_saddress, 0);
        chk({p, "_wdata"}, m_sdata_out, 0);
        chk({p, "_swr"}, m_swr, 0);
        chk({p, "_srd"}, m_srd, 0);
        chk({p, "_busy"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        msg_t m, ma;
        int n, ins, puts, reads;
        @(negedge clk);
        chk_reset("rst");
        @(posedge clk);
        #1 n_reset = 1'b1;
        // check string "123456789"
        m = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        send(m, 32'hE3069283, 1'b0);
        wait_idle("t1_done");
        // single zero byte: exact access sequence
        log_q.delete();
        m = {8'h00};
        send(m, crc_msg(m), 1'b0);
        wait_idle("t2_done");
        n = log_q.size();
        chk("t2_len", n >= 6, 1);
        if (n >= 6) begin
            chk("t2_clr", pk(log_q[0]), {1'b1, ADDR_CTRL, CTRL_CLR});
            chk("t2_in", pk(log_q[1]), {1'b1, ADDR_IN, 32'h0});
            chk("t2_put", pk(log_q[2]), {1'b1, ADDR_CTRL, CTRL_PUT});
            chk("t2_get", pk(log_q[3]), {1'b1, ADDR_CTRL, CTRL_GET});
            for (int i = 4; i < n - 1; i++) chk("t2_state_rd", pk(log_q[i]), {1'b0, ADDR_STATE, 32'h0});
            chk("t2_result_rd", pk(log_q[n-1]), {1'b0, ADDR_RESULT, 32'h0});
        end
        // 251 bytes: overflow, drained through last
        log_q.delete();
        m.delete();
        for (int i = 0; i < 251; i++) m.push_back(8'(i));
        send(m, 32'h0, 1'b1);
        wait_idle("t3_done");
        ins = 0;
        puts = 0;
        foreach (log_q[i]) begin
            if (log_q[i].wr && log_q[i].a == ADDR_IN) ins++;
            if (log_q[i].wr && log_q[i].a == ADDR_CTRL && log_q[i].d == CTRL_PUT) puts++;
        end
        chk("t3_in_writes", ins, 250);
        chk("t3_put_writes", puts, 250);
        repeat (10) @(negedge clk);
        chk("t3_stays_idle", busy, 0);
        @(posedge clk);
        #1;
        // engine stuck BUSY: poll timeout
        stuck = 1;
        log_q.delete();
        m = {8'hA5};
        send(m, 32'h0, 1'b1);
        wait_idle("t4_done");
        reads = 0;
        foreach (log_q[i]) if (!log_q[i].wr && log_q[i].a == ADDR_STATE) reads++;
        chk("t4_state_reads", reads, 1024);
        stuck = 0;
        // result backpressure while next message fills the FIFO
        r_ready = 1'b0;
        ma = {8'h10, 8'h20, 8'h30, 8'h40};
        send(ma, crc_msg(ma), 1'b0);
        n = 0;
        @(negedge clk);
        while (!r_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_valid", r_valid, 1);
        @(posedge clk);
        #1;
        m.delete();
        for (int i = 0; i < 16; i++) m.push_back(8'(8'hE0 + i));
        send(m, crc_msg(m), 1'b0);
        @(negedge clk);
        chk("t5_full_ready", s_ready, 0);
        repeat (20) begin
            @(negedge clk);
            chk("t5_hold_crc", r_crc, crc_msg(ma));
            chk("t5_hold_valid", r_valid, 1);
        end
        @(posedge clk);
        #1 r_ready = 1'b1;
        wait_idle("t5_done");
        // reset during the PUT wait of byte 5
        m.delete();
        for (int i = 0; i < 10; i++) m.push_back(8'(8'h70 + i));
        send(m, crc_msg(m), 1'b0);
        n = 0;
        while (put_cnt != 5 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("t6_put5", put_cnt, 5);
        @(posedge clk);
        #1 n_reset = 1'b0;
        #1 chk_reset("t6_rst");
        sb.delete();
        @(posedge clk);
        #1 n_reset = 1'b1;
        log_q.delete();
        m = {8'h5A, 8'hC3};
        send(m, crc_msg(m), 1'b0);
        wait_idle("t6_done");
        chk("t6_log_len", log_q.size() >= 1, 1);
        if (log_q.size() >= 1) chk("t6_first_clr", pk(log_q[0]), {1'b1, ADDR_CTRL, CTRL_CLR});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
